// File: rtl/soc_uart_pkg.sv
// soc_uart_pkg
//   Shared definitions for the UART receive path: default frame geometry and
//   the receiver FSM state encoding.
//   Optional feature macro: SOC_UART_RX_PARITY_EN (adds the PARITY state).
package soc_uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef SOC_UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/soc_sync_2ff.sv
// soc_sync_2ff
//   Two-flop synchronizer for a single asynchronous level.
//   Ports:
//     clk  - destination clock
//     rst  - synchronous active-high reset, loads RST_VAL into both flops
//     d    - asynchronous input
//     q    - synchronized output (two clk cycles of latency)
module soc_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/soc_uart_rx.sv
// soc_uart_rx
//   Oversampling UART receiver with a one-entry holding register.
//   Optional feature macro: SOC_UART_RX_PARITY_EN (even parity bit after data).
//   Ports:
//     uart_clk    - OVERSAMPLE x baud clock, sole clock
//     rst         - synchronous active-high reset
//     rx          - asynchronous serial line, idle high
//     rx_data     - received word, stable while rx_valid
//     rx_valid    - rx_data holds an unconsumed word
//     rx_ready    - consumer takes rx_data in a cycle with rx_valid
//     frame_err   - one-cycle pulse, stop bit sampled low
//     overrun_err - one-cycle pulse, completed word dropped (holding reg full)
//     parity_err  - one-cycle pulse, parity mismatch (0 without parity)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | line idle, waiting for rx_s low
//   START      | wait half a bit, re-check start bit (glitch reject)
//   DATA       | sample one data bit every OVERSAMPLE cycles, LSB first
//   PARITY     | sample parity bit and record mismatch (macro only)
//   STOP       | sample stop bit, deliver word or flag framing error
//   WAIT_IDLE  | after a framing error, wait for line to return high
module soc_uart_rx
  import soc_uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 uart_clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 rx_s;
  logic [CW-1:0]        cyc_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;

  logic cyc_half;
  logic cyc_last;
  logic bit_last;

  logic cnt_clr;
  logic bit_clr;
  logic shift_en;
  logic stop_ok;
  logic stop_bad;
  logic frame_good;
`ifdef SOC_UART_RX_PARITY_EN
  logic par_cap;
  logic par_bad;
`endif

  soc_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (uart_clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign cyc_half = (cyc_cnt == CYC_HALF);
  assign cyc_last = (cyc_cnt == CYC_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (cyc_half) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (cyc_last && bit_last) begin
`ifdef SOC_UART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef SOC_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cyc_last) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (cyc_last) state_nxt = rx_s ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter and sampling strobes. The cycle counter free-runs inside a bit
  // period and is cleared at each sample point, so OVERSAMPLE need not be a
  // power of two.
  always_comb begin
    cnt_clr  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef SOC_UART_RX_PARITY_EN
    par_cap  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
      ST_START: begin
        if (cyc_half) begin
          cnt_clr = 1'b1;
          bit_clr = 1'b1;
        end
      end
      ST_DATA: begin
        if (cyc_last) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
        end
      end
`ifdef SOC_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cyc_last) begin
          cnt_clr = 1'b1;
          par_cap = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cyc_last) begin
          cnt_clr  = 1'b1;
          stop_ok  = rx_s;
          stop_bad = ~rx_s;
        end
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      if (cnt_clr) begin
        cyc_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      end
    end
  end

`ifdef SOC_UART_RX_PARITY_EN
  // Mismatch is held until the stop bit so that a framing error can take
  // precedence and only one error pulse is produced per frame.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (bit_clr) begin
        par_bad <= 1'b0;
      end else if (par_cap) begin
        par_bad <= rx_s ^ (^shift_q);
      end
      parity_err <= stop_ok & par_bad;
    end
  end

  assign frame_good = stop_ok & ~par_bad;
`else
  assign parity_err = 1'b0;
  assign frame_good = stop_ok;
`endif

  // A consume in the completion cycle frees the holding register, so the new
  // word is loaded instead of being counted as an overrun.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= frame_good & rx_valid & ~rx_ready;
      if (frame_good && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_soc_uart_rx.sv
module tb_soc_uart_rx;
  import soc_uart_pkg::*;

`ifdef SOC_UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int OS   = 16;
  localparam int NCYC = (10 + PB) * OS;
  // Line-to-rx_valid: two synchronizer cycles plus the rx_s-based latency.
  localparam int LAT  = OS / 2 + OS * (9 + PB) + 1 + 2;

  logic       uart_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  soc_uart_rx dut (
    .uart_clk    (uart_clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 uart_clk = ~uart_clk;

  int cyc = 0;
  always @(posedge uart_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int valid_cnt, vhi_cnt, ferr_cnt, oerr_cnt, perr_cnt, valid_cyc, start_cyc;
  logic [7:0] last_data;
  logic       valid_d = 1'b0;

  always @(negedge uart_clk) begin
    if (rst) begin
      valid_d = 1'b0;
    end else begin
      if (frame_err)   ferr_cnt++;
      if (overrun_err) oerr_cnt++;
      if (parity_err)  perr_cnt++;
      if (rx_valid)    vhi_cnt++;
      if (rx_valid && !valid_d) begin
        valid_cnt++;
        last_data = rx_data;
        valid_cyc = cyc;
      end
      valid_d = rx_valid;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    vhi_cnt   = 0;
    ferr_cnt  = 0;
    oerr_cnt  = 0;
    perr_cnt  = 0;
    valid_cyc = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge uart_clk);
  endtask

  // Drives one frame starting at a negedge. ready_at pulses rx_ready for one
  // cycle at that bit-cycle index; rst_at asserts rst there and returns.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit,
                            input int low_tail, input int ready_at, input int rst_at);
    logic [10:0] bits;
    bits = {stop_bit, stop_bit, d, 1'b0};
    if (PB == 1) bits[9] = par;
    start_cyc = cyc;
    for (int i = 0; i < NCYC; i++) begin
      rx = bits[4'(i / OS)];
      if (ready_at >= 0) begin
        if (i == ready_at)     rx_ready = 1'b1;
        if (i == ready_at + 1) rx_ready = 1'b0;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge uart_clk);
        return;
      end
      @(negedge uart_clk);
    end
    repeat (low_tail) @(negedge uart_clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1, 0};
    vecs[1] = '{8'hC3, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'hA3, 1'b0, 0, 1};
    vecs[5] = '{8'h0F, 1'b1, 1, 0};

    clear_counts();
    repeat (5) @(negedge uart_clk);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_errs", {29'd0, frame_err, overrun_err, parity_err}, 0);
    rst = 1'b0;
    idle(5);

    // Start-bit glitch shorter than half a bit.
    rx_ready = 1'b1;
    clear_counts();
    rx = 1'b0;
    repeat (4) @(negedge uart_clk);
    idle(30);
    check("glitch_valid", 32'(valid_cnt), 0);
    check("glitch_errs", 32'(ferr_cnt + oerr_cnt + perr_cnt), 0);
    check("glitch_state", 32'(dut.state), 32'(ST_IDLE));

    for (int v = 0; v < 6; v++) begin
      clear_counts();
      send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop_bit,
                 vecs[v].stop_bit ? 0 : 32, -1, -1);
      idle(20);
      check($sformatf("vec%0d_valid", v), 32'(valid_cnt), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_vhigh", v), 32'(vhi_cnt), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid != 0)
        check($sformatf("vec%0d_data", v), 32'(last_data), 32'(vecs[v].data));
      check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_oerr", v), 32'(oerr_cnt), 0);
      check($sformatf("vec%0d_perr", v), 32'(perr_cnt), 0);
      if (v == 0) check("latency", 32'(valid_cyc - start_cyc), 32'(LAT));
    end

    // Overrun: second word dropped while the first is unconsumed.
    rx_ready = 1'b0;
    clear_counts();
    send_frame(8'h11, ^8'h11, 1'b1, 0, -1, -1);
    idle(10);
    send_frame(8'h22, ^8'h22, 1'b1, 0, -1, -1);
    idle(20);
    check("ovr_valid", 32'(rx_valid), 1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(oerr_cnt), 1);
    check("ovr_ferr", 32'(ferr_cnt), 0);
    rx_ready = 1'b1;
    @(negedge uart_clk);
    rx_ready = 1'b0;
    check("ovr_consume", 32'(rx_valid), 0);
    idle(5);

    // Consume in the same cycle as completion: new word replaces old.
    send_frame(8'h5A, ^8'h5A, 1'b1, 0, -1, -1);
    idle(10);
    clear_counts();
    send_frame(8'hA5, ^8'hA5, 1'b1, 0, LAT - 1, -1);
    idle(20);
    check("same_oerr", 32'(oerr_cnt), 0);
    check("same_valid", 32'(rx_valid), 1);
    check("same_data", 32'(rx_data), 32'hA5);
    rx_ready = 1'b1;
    @(negedge uart_clk);
    rx_ready = 1'b0;
    idle(5);

    // Reset in the middle of data bit 4 with a word pending.
    send_frame(8'h66, ^8'h66, 1'b1, 0, -1, -1);
    idle(10);
    clear_counts();
    send_frame(8'hFF, ^8'hFF, 1'b1, 0, -1, OS * 5 + OS / 2);
    check("mrst_valid", 32'(rx_valid), 0);
    check("mrst_data", 32'(rx_data), 0);
    check("mrst_errs", {29'd0, frame_err, overrun_err, parity_err}, 0);
    repeat (2) @(negedge uart_clk);
    rst = 1'b0;
    idle(20);
    check("mrst_nopulse", 32'(ferr_cnt + oerr_cnt + perr_cnt + valid_cnt), 0);
    rx_ready = 1'b1;
    clear_counts();
    send_frame(8'h3C, ^8'h3C, 1'b1, 0, -1, -1);
    idle(20);
    check("mrst_next_valid", 32'(valid_cnt), 1);
    check("mrst_next_data", 32'(last_data), 32'h3C);

`ifdef SOC_UART_RX_PARITY_EN
    clear_counts();
    send_frame(8'h07, 1'b0, 1'b1, 0, -1, -1);
    idle(20);
    check("par_bad_perr", 32'(perr_cnt), 1);
    check("par_bad_valid", 32'(valid_cnt), 0);
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1, 0, -1, -1);
    idle(20);
    check("par_ok_valid", 32'(valid_cnt), 1);
    check("par_ok_data", 32'(last_data), 32'h07);
    check("par_ok_latency", 32'(valid_cyc - start_cyc), 32'(LAT));
    check("par_ok_perr", 32'(perr_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
